lcd_bus_arbiter: RTL
====================

Name: lcd_bus_arbiter

Overview:
- Owns the physical HD44780/LCD1602 pin bus (rs, rw, enable, data).
- Shares the bus between two requesters, for example a text-refresh engine and a status/command writer, using round-robin arbitration.
- After power-up, runs the fixed init sequence itself. Only then does it grant requesters.
- Generates per-transfer setup, enable-pulse and execution-wait timing from the system clock, so requesters never handle LCD timing.

Parameters:
- DATA_BITS, 8, width of the LCD data bus and requester data.
- POWERUP_CYCLES, 750000, wait after reset before the first init command (15 ms at 50 MHz).
- SETUP_CYCLES, 2, cycles rs/data are stable with enable low before the enable rising edge.
- EN_PULSE_CYCLES, 25, enable high width in cycles.
- EXEC_CYCLES, 2000, wait after the enable falling edge for normal commands and data.
- LONG_EXEC_CYCLES, 82000, wait after the enable falling edge for clear/home commands.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- req_i, input, 2, per-requester transfer request; level, held until the matching gnt_o.
- rs0_i, input, 1, requester 0 register select (0 = command, 1 = character).
- data0_i, input, DATA_BITS, requester 0 byte.
- rs1_i, input, 1, requester 1 register select.
- data1_i, input, DATA_BITS, requester 1 byte.
- gnt_o, output, 2, one-cycle accept pulse; rs/data are sampled on this cycle.
- done_o, output, 2, one-cycle pulse when the granted transfer's execution wait ends.
- ready_o, output, 1, high once the init sequence has completed.
- busy_o, output, 1, high whenever the FSM is not in IDLE.
- rs, output, 1, LCD register select.
- rw, output, 1, LCD read/write; constant 0 (write-only).
- enable, output, 1, LCD enable strobe.
- data, output, DATA_BITS, LCD data bus.

Behaviour:
- Reset (asynchronous, reset == 0), effective immediately, including mid-transfer:
  - rs=0, rw=0, enable=0, data=0, gnt_o=0, done_o=0, ready_o=0, busy_o=1.
  - FSM returns to POWERUP; init index cleared; round-robin pointer set to favour requester 0.
  - An in-flight transfer is dropped with no done_o.
- FSM states: POWERUP, INIT_LOAD, SETUP, PULSE, WAIT, IDLE.
  - POWERUP: counts POWERUP_CYCLES, then goes to INIT_LOAD.
  - INIT_LOAD: loads init command [idx] into rs=0/data. The sequence is 0x38, 0x06, 0x0C, 0x01. Goes to SETUP.
  - SETUP: enable=0 for SETUP_CYCLES, then goes to PULSE.
  - PULSE: enable=1 for EN_PULSE_CYCLES, then enable=0 and go to WAIT.
  - WAIT: rs/data held; counts LONG_EXEC_CYCLES if the latched transfer is long, otherwise EXEC_CYCLES. A transfer is long when rs=0 and data is 0x01, 0x02 or 0x03.
  - WAIT exit, init transfer: if it was init index 3, set ready_o=1 and go to IDLE; otherwise idx+1 and go to INIT_LOAD.
  - WAIT exit, requester transfer: done_o[owner]=1 on the last WAIT cycle, then go to IDLE.
  - IDLE: busy_o=0. If any req_i bit is set, pick a winner, pulse gnt_o[winner], latch its rs/data, drive them on rs/data the next cycle, and go to SETUP.
- Arbitration:
  - Round-robin. If both requesters request in the same cycle, the one not granted last wins. A single requester always wins.
  - Pointer updates on each grant.
  - req_i is ignored outside IDLE. No grant is issued before ready_o=1.
- Latency:
  - Grant occurs the cycle after IDLE is entered with req pending, or in the same cycle if req is already high on entry.
  - Enable rises SETUP_CYCLES+1 cycles after gnt_o.
  - done_o asserts SETUP_CYCLES + EN_PULSE_CYCLES + exec cycles + 1 cycles after gnt_o.
  - Earliest next grant is the cycle after done_o.
- Stability: rs/data change only in INIT_LOAD or on the cycle after a grant; never while enable=1 or during WAIT.
- Counter widths: $clog2 of the largest count parameter. All counters restart at 0 on every state entry.
- gnt_o and done_o are never both high for different owners in the same cycle. At most one bit of each is high.

Test Plan:
Overrides for all tests: POWERUP_CYCLES=8, SETUP_CYCLES=2, EN_PULSE_CYCLES=3, EXEC_CYCLES=5, LONG_EXEC_CYCLES=10.
- Init sequence: release reset with no requests.
  - Required: exactly 4 enable pulses carrying data 0x38, 0x06, 0x0C, 0x01, all with rs=0, each pulse 3 cycles wide.
  - Required: first rising edge after 8+ cycles; gap after 0x01 uses the 10-cycle wait; ready_o rises afterwards; gnt_o stays 0 throughout.
- Single transfer: after ready, req_i=01 with rs0_i=1, data0_i=0x41.
  - Required: gnt_o=01 for one cycle; rs=1, data=0x41 on the bus; enable high 3 cycles starting 3 cycles after the grant.
  - Required: done_o=01 exactly 11 cycles after the grant.
- Contention: req_i=11 held continuously.
  - Required: grants alternate 01, 10, 01, 10.
  - Required: each next grant comes the cycle after the previous done_o; bus data matches the granted requester.
- Long command: requester 1 sends rs=0, data=0x01.
  - Required: done_o=10 at 16 cycles after the grant, versus 11 cycles for a short command.
- Reset mid-pulse: assert reset while enable=1.
  - Required: enable/rs/data drop to 0 and ready_o=0 immediately; no done_o.
  - Required: after release, the full init sequence repeats.
- Request before ready: hold req_i=10 from reset release.
  - Required: no gnt_o until ready_o=1; gnt_o=10 follows within one cycle of ready.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Owns the HD44780 pin bus: runs the power-up init sequence, then round-robins two writers.
// Latency: enable rises SETUP+1 cycles after gnt_o, done_o SETUP+PULSE+exec+1 cycles after gnt_o.
// Backpressure: req_i is a level held until gnt_o; requests are only considered while IDLE.
module lcd_bus_arbiter #(
  parameter int DATA_BITS        = 8,
  parameter int POWERUP_CYCLES   = 750000,
  parameter int SETUP_CYCLES     = 2,
  parameter int EN_PULSE_CYCLES  = 25,
  parameter int EXEC_CYCLES      = 2000,
  parameter int LONG_EXEC_CYCLES = 82000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_i,
  input  logic                 rs0_i,
  input  logic [DATA_BITS-1:0] data0_i,
  input  logic                 rs1_i,
  input  logic [DATA_BITS-1:0] data1_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           done_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 rs,
  output logic                 rw,
  output logic                 enable,
  output logic [DATA_BITS-1:0] data
);

  // Counter sized for the largest interval; WAIT counts up to and including the exec value.
  localparam int MAX_A   = (POWERUP_CYCLES > LONG_EXEC_CYCLES) ? POWERUP_CYCLES : LONG_EXEC_CYCLES;
  localparam int MAX_B   = (EXEC_CYCLES > EN_PULSE_CYCLES) ? EXEC_CYCLES : EN_PULSE_CYCLES;
  localparam int MAX_C   = (MAX_B > SETUP_CYCLES) ? MAX_B : SETUP_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(EN_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] EXEC_PRE   = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_EXEC_CYCLES);
  localparam logic [CW-1:0] LONG_PRE   = CW'(LONG_EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_POWERUP   = 3'd0,
    S_INIT_LOAD = 3'd1,
    S_SETUP     = 3'd2,
    S_PULSE     = 3'd3,
    S_WAIT      = 3'd4,
    S_IDLE      = 3'd5
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           idx_q;
  logic                 ptr_q;    // requester favoured on a tie
  logic                 owner_q;  // requester that owns the current transfer
  logic                 init_q;   // current transfer belongs to the init sequence
  logic [1:0]           gnt_q;
  logic [1:0]           done_q;
  logic                 ready_q;
  logic                 rs_q;
  logic                 enable_q;
  logic [DATA_BITS-1:0] data_q;

  logic                 long_xfer;
  logic [CW-1:0]        wait_last;
  logic [CW-1:0]        wait_pre;
  logic                 win;

  // Fixed HD44780 init: 8-bit/2-line, entry increment, display on, clear.
  function automatic logic [DATA_BITS-1:0] init_cmd(input logic [1:0] i);
    logic [DATA_BITS-1:0] c;
    case (i)
      2'd0:    c = DATA_BITS'(8'h38);
      2'd1:    c = DATA_BITS'(8'h06);
      2'd2:    c = DATA_BITS'(8'h0C);
      default: c = DATA_BITS'(8'h01);
    endcase
    return c;
  endfunction

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  always_comb begin
    long_xfer = !rs_q && ((data_q == DATA_BITS'(1)) || (data_q == DATA_BITS'(2)) ||
                          (data_q == DATA_BITS'(3)));
    wait_last = long_xfer ? LONG_LAST : EXEC_LAST;
    wait_pre  = long_xfer ? LONG_PRE  : EXEC_PRE;
  end

  // Round-robin pick: a lone requester wins, a tie goes to the favoured one.
  always_comb begin
    win = 1'b0;
    if (req_i == 2'b11) begin
      win = ptr_q;
    end else begin
      win = req_i[1];
    end
  end

  // Main sequencer: power-up wait, init commands, then setup/pulse/wait per granted transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_POWERUP;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      init_q   <= 1'b1;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      ready_q  <= 1'b0;
      rs_q     <= 1'b0;
      enable_q <= 1'b0;
      data_q   <= '0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        S_POWERUP: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q   <= '0;
            state_q <= S_INIT_LOAD;
          end
        end
        S_INIT_LOAD: begin
          rs_q    <= 1'b0;
          data_q  <= init_cmd(idx_q);
          init_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            enable_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            enable_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done_o lands on the final WAIT cycle, so it is scheduled one count early.
          if (!init_q && (cnt_q == wait_pre)) begin
            done_q <= owner_q ? 2'b10 : 2'b01;
          end
          if (cnt_q == wait_last) begin
            cnt_q <= '0;
            if (init_q && (idx_q != 2'd3)) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_INIT_LOAD;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
              // A request already pending on IDLE entry is granted in the first IDLE cycle.
              if (req_i != 2'b00) begin
                gnt_q   <= win ? 2'b10 : 2'b01;
                owner_q <= win;
                ptr_q   <= ~win;
              end
            end
          end
        end
        S_IDLE: begin
          cnt_q <= '0;
          if (gnt_q != 2'b00) begin
            // Grant cycle: capture the winner's byte, bus changes on the next cycle.
            rs_q    <= owner_q ? rs1_i : rs0_i;
            data_q  <= owner_q ? data1_i : data0_i;
            init_q  <= 1'b0;
            state_q <= S_SETUP;
          end else if (req_i != 2'b00) begin
            gnt_q   <= win ? 2'b10 : 2'b01;
            owner_q <= win;
            ptr_q   <= ~win;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_POWERUP;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign ready_o = ready_q;
  assign busy_o  = (state_q != S_IDLE);
  assign rs      = rs_q;
  assign rw      = 1'b0;
  assign enable  = enable_q;
  assign data    = data_q;

endmodule
